// File: rtl/alu_arb_pkg.sv
// Shared opcode, flag and struct definitions for the ALU arbiter slice.
package alu_arb_pkg;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRL = 3'd6;
   localparam logic [2:0] OP_SRA = 3'd7;

   localparam int FLAG_OV   = 2;
   localparam int FLAG_SIGN = 1;
   localparam int FLAG_ZERO = 0;

   localparam int SHAMT_W = 5;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        cin;
   } alu_req_t;

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  flags;
   } alu_rsp_t;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic is_shift(input logic [2:0] op);
      return op >= OP_SLL;
   endfunction
endpackage

// File: rtl/alu32.sv
// Shared 32-bit ALU. The adder runs for every opcode, so its overflow output is
// only meaningful for ADD/SUB; callers must mask it for the other ops.
module alu32
   import alu_arb_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   input  logic        cin_i,
   output logic [31:0] result_o,
   output logic [2:0]  flags_o
);
   logic [31:0] b_eff;
   logic [31:0] sum;
   logic        c_eff;
   logic        ov_raw;

   always_comb begin
      // SUB computes a - b - cin as a + ~b + !cin.
      b_eff  = (op_i == OP_SUB) ? ~b_i : b_i;
      c_eff  = (op_i == OP_SUB) ? ~cin_i : cin_i;
      sum    = a_i + b_eff + {31'b0, c_eff};
      ov_raw = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
      case (op_i)
         OP_ADD, OP_SUB: result_o = sum;
         OP_AND:         result_o = a_i & b_i;
         OP_OR:          result_o = a_i | b_i;
         OP_XOR:         result_o = a_i ^ b_i;
         OP_SLL:         result_o = a_i << b_i[SHAMT_W-1:0];
         OP_SRL:         result_o = a_i >> b_i[SHAMT_W-1:0];
         default:        result_o = 32'($signed(a_i) >>> b_i[SHAMT_W-1:0]);
      endcase
      flags_o            = '0;
      flags_o[FLAG_OV]   = ov_raw;
      flags_o[FLAG_SIGN] = result_o[31];
      flags_o[FLAG_ZERO] = (result_o == 32'd0);
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over an eligible vector, searching from ptr.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] eligible_i,
   output logic [N-1:0] grant_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   cand;
   logic [PW:0]   nxt;
   logic          found;

   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      cand    = '0;
      nxt     = '0;
      for (int off = 0; off < N; off++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(off);
         if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
         if (!found && eligible_i[cand[PW-1:0]]) begin
            found                   = 1'b1;
            grant_o[cand[PW-1:0]]   = 1'b1;
            nxt                     = cand + 1'b1;
            if (nxt == (PW+1)'(N)) nxt = '0;
            ptr_d                   = nxt[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters; results land in per-requester slots that
// hold until the owner drains them.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int CNTW = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0][31:0] req_a,
   input  logic [NREQ-1:0][31:0] req_b,
   input  logic [NREQ-1:0][2:0]  req_op,
   input  logic [NREQ-1:0]       req_cin,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [NREQ-1:0][31:0] rsp_result,
   output logic [NREQ-1:0][2:0]  rsp_flags,
   output logic [CNTW-1:0]       grant_count
);
   logic [NREQ-1:0]       eligible;
   logic [NREQ-1:0]       grant;
   alu_req_t              alu_in;
   alu_rsp_t              alu_out;
   logic [2:0]            flags_clean;

   logic [NREQ-1:0]       vld_q, vld_d;
   logic [NREQ-1:0][31:0] res_q, res_d;
   logic [NREQ-1:0][2:0]  flg_q, flg_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;

   // Gating with rst_n keeps req_ready low during the reset cycle.
   assign eligible  = {NREQ{rst_n}} & req_valid & (~vld_q | rsp_ready);
   assign req_ready = grant;

   rr_arbiter #(.N(NREQ)) u_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .eligible_i (eligible),
      .grant_o    (grant)
   );

   always_comb begin
      alu_in = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            alu_in.a   = req_a[i];
            alu_in.b   = req_b[i];
            alu_in.op  = req_op[i];
            alu_in.cin = req_cin[i];
         end
      end
      if (is_shift(alu_in.op)) alu_in.b = {{(32-SHAMT_W){1'b0}}, alu_in.b[SHAMT_W-1:0]};
      if (!is_arith(alu_in.op)) alu_in.cin = 1'b0;
   end

   alu32 u_alu (
      .a_i      (alu_in.a),
      .b_i      (alu_in.b),
      .op_i     (alu_in.op),
      .cin_i    (alu_in.cin),
      .result_o (alu_out.result),
      .flags_o  (alu_out.flags)
   );

   always_comb begin
      flags_clean = alu_out.flags;
      if (!is_arith(alu_in.op)) flags_clean[FLAG_OV] = 1'b0;
   end

   // A grant wins over a drain on the same slot, so the slot stays full.
   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      flg_d = flg_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            vld_d[i] = 1'b1;
            res_d[i] = alu_out.result;
            flg_d[i] = flags_clean;
         end else if (rsp_ready[i]) begin
            vld_d[i] = 1'b0;
         end
      end
      if (|grant) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         res_q <= '0;
         flg_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         res_q <= res_d;
         flg_q <= flg_d;
         cnt_q <= cnt_d;
      end
   end

   assign rsp_valid   = vld_q;
   assign rsp_result  = res_q;
   assign rsp_flags   = flg_q;
   assign grant_count = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference model predicts grants, slot state
// and ALU results each cycle; directed checks cover the listed scenarios.
module tb_alu_arbiter;
   localparam int NREQ = 2;
   localparam int CNTW = 16;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0][31:0] req_a;
   logic [NREQ-1:0][31:0] req_b;
   logic [NREQ-1:0][2:0]  req_op;
   logic [NREQ-1:0]       req_cin;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [NREQ-1:0][31:0] rsp_result;
   logic [NREQ-1:0][2:0]  rsp_flags;
   logic [CNTW-1:0]       grant_count;

   alu_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_op      (req_op),
      .req_cin     (req_cin),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags),
      .grant_count (grant_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference ALU: {flags[2:0], result[31:0]} computed with wide signed arithmetic.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic cin);
      logic [31:0] r, bm;
      logic        ov;
      longint      s;
      bm = (op >= 3'd5) ? (b & 32'h1F) : b;
      ov = 1'b0;
      s  = 0;
      case (op)
         3'd0: begin
            s  = longint'($signed(a)) + longint'($signed(bm)) + longint'(cin);
            r  = s[31:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            s  = longint'($signed(a)) - longint'($signed(bm)) - longint'(cin);
            r  = s[31:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2:    r = a & bm;
         3'd3:    r = a | bm;
         3'd4:    r = a ^ bm;
         3'd5:    r = a << bm[4:0];
         3'd6:    r = a >> bm[4:0];
         default: r = 32'($signed(a) >>> bm[4:0]);
      endcase
      return {ov, r[31], (r == 32'd0), r};
   endfunction

   logic [34:0]     sb0[$];
   logic [34:0]     sb1[$];
   logic [NREQ-1:0] m_vld;
   logic [NREQ-1:0] pend;
   logic [NREQ-1:0] exp_rdy;
   logic [CNTW-1:0] m_cnt;
   logic [34:0]     ent;
   int              m_ptr;
   logic            mon_en;

   // Per-cycle reference: compare slots captured last cycle, predict this cycle's grant.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
               if (i == 0) ent = sb0.pop_front();
               else        ent = sb1.pop_front();
               chk("sb_result", rsp_result[i], ent[31:0]);
               chk("sb_flags", 32'(rsp_flags[i]), 32'(ent[34:32]));
            end
         end
         chk("sb_rsp_valid", 32'(rsp_valid), 32'(m_vld));
         chk("sb_grant_count", 32'(grant_count), 32'(m_cnt));
         exp_rdy = '0;
         if (rst_n) begin
            for (int off = 0; off < NREQ; off++) begin
               int k;
               k = (m_ptr + off) % NREQ;
               if (exp_rdy == '0 && req_valid[k] && (!m_vld[k] || rsp_ready[k])) exp_rdy[k] = 1'b1;
            end
         end
         chk("sb_req_ready", 32'(req_ready), 32'(exp_rdy));
         pend = '0;
         if (!rst_n) begin
            m_vld = '0;
            m_ptr = 0;
            m_cnt = '0;
            sb0.delete();
            sb1.delete();
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               if (exp_rdy[i]) begin
                  if (i == 0) sb0.push_back(model(req_a[i], req_b[i], req_op[i], req_cin[i]));
                  else        sb1.push_back(model(req_a[i], req_b[i], req_op[i], req_cin[i]));
                  pend[i]  = 1'b1;
                  m_vld[i] = 1'b1;
                  m_ptr    = (i + 1) % NREQ;
                  m_cnt    = m_cnt + 1'b1;
               end else if (rsp_ready[i]) begin
                  m_vld[i] = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic cin);
      req_a[i]   = a;
      req_b[i]   = b;
      req_op[i]  = op;
      req_cin[i] = cin;
   endtask

   logic [31:0] t_a[8];
   logic [31:0] t_b[8];
   logic [2:0]  t_op[8];
   logic        t_cin[8];

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
      req_a = '0; req_b = '0; req_op = '0; req_cin = '0;
      m_vld = '0; pend = '0; exp_rdy = '0; m_cnt = '0; m_ptr = 0; mon_en = 1'b0; ent = '0;

      // Reset and idle
      tick();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("idle_result0", rsp_result[0], 32'd0);
         chk("idle_result1", rsp_result[1], 32'd0);
         chk("idle_grant_count", 32'(grant_count), 32'd0);
         chk("idle_req_ready", 32'(req_ready), 32'd0);
         tick();
      end

      // Single ADD with signed overflow
      set_req(0, 32'h7FFFFFFF, 32'd1, 3'd0, 1'b0);
      req_valid = 2'b01;
      @(negedge clk);
      chk("add_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("add_result", rsp_result[0], 32'h80000000);
      chk("add_flags", 32'(rsp_flags[0]), 32'd6);
      chk("add_count", 32'(grant_count), 32'd1);
      chk("add_valid", 32'(rsp_valid), 32'd1);
      tick();

      // Reset so contention starts from ptr 0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Contention with continuous drain
      set_req(0, 32'd2, 32'd3, 3'd0, 1'b0);
      set_req(1, 32'd5, 32'd5, 3'd1, 1'b0);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_order", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k >= 2) begin
            chk("rr_result0", rsp_result[0], 32'd5);
            chk("rr_result1", rsp_result[1], 32'd0);
            chk("rr_flags1", 32'(rsp_flags[1]), 32'd1);
         end
         tick();
      end

      // Backpressure on requester 1
      req_valid = '0;
      tick();
      req_valid = 2'b11;
      rsp_ready = 2'b01;
      @(negedge clk);
      chk("bp_first", 32'(req_ready), 32'd1);
      tick();
      @(negedge clk);
      chk("bp_grant1", 32'(req_ready), 32'd2);
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_held", 32'(req_ready), 32'd1);
         tick();
      end
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("bp_regrant", 32'(req_ready), 32'd2);
      tick();
      req_valid = '0;
      tick();

      // Shift masking, flag cleanup and assorted ops on requester 0
      t_a[0] = 32'h7FFFFFFF; t_b[0] = 32'd1;        t_op[0] = 3'd0; t_cin[0] = 1'b0;
      t_a[1] = 32'd1;        t_b[1] = 32'h21;       t_op[1] = 3'd5; t_cin[1] = 1'b0;
      t_a[2] = 32'h7FFFFFFF; t_b[2] = 32'h7FFFFFFF; t_op[2] = 3'd2; t_cin[2] = 1'b1;
      t_a[3] = 32'h80000000; t_b[3] = 32'h24;       t_op[3] = 3'd7; t_cin[3] = 1'b0;
      t_a[4] = 32'h80000000; t_b[4] = 32'h3F;       t_op[4] = 3'd6; t_cin[4] = 1'b1;
      t_a[5] = 32'h80000000; t_b[5] = 32'd1;        t_op[5] = 3'd1; t_cin[5] = 1'b1;
      t_a[6] = 32'hFFFFFFFF; t_b[6] = 32'd0;        t_op[6] = 3'd0; t_cin[6] = 1'b1;
      t_a[7] = 32'h40000000; t_b[7] = 32'h40000000; t_op[7] = 3'd3; t_cin[7] = 1'b1;
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      for (int k = 0; k < 8; k++) begin
         set_req(0, t_a[k], t_b[k], t_op[k], t_cin[k]);
         @(negedge clk);
         if (k == 2) begin
            chk("shift_result", rsp_result[0], 32'd2);
            chk("shift_ov", 32'(rsp_flags[0][2]), 32'd0);
         end
         if (k == 3) chk("and_ov_clean", 32'(rsp_flags[0]), 32'd0);
         tick();
      end
      req_valid = '0;
      tick();

      // Reset mid-stream: slot 0 full, requester 1 requesting
      rsp_ready = '0;
      set_req(0, 32'd1, 32'd1, 3'd0, 1'b0);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b10;
      @(negedge clk);
      chk("mid_grant1", 32'(req_ready), 32'd2);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_count", 32'(grant_count), 32'd0);
      chk("mid_first_grant", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0;
      repeat (3) tick();

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between NREQ independent requesters, such as the execute stage, the branch-compare unit and the address generator. Each requester issues operations through a valid/ready handshake. Grants are round-robin, at most one operation per cycle. Each result is registered into a per-requester response slot with cleaned-up status flags, and the slot holds until the owner consumes it.

## Interface
- NREQ, 2: number of requesters, 2..4.
- CNTW, 16: width of the grant counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  requester i is granted this cycle; the handshake fires when valid && ready.
- req_a  in  NREQ*32  operand A, slice i.
- req_b  in  NREQ*32  operand B, slice i.
- req_op  in  NREQ*3  ALU opcode, slice i (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5..7 shifts).
- req_cin  in  NREQ  carry/borrow-in, used by ADD and SUB only.
- rsp_valid  out  NREQ  response slot i is full.
- rsp_ready  in  NREQ  requester i consumes its slot.
- rsp_result  out  NREQ*32  registered result, slice i.
- rsp_flags  out  NREQ*3  registered flags, slice i: [2] overflow, [1] sign, [0] zero.
- grant_count  out  CNTW  total handshakes since reset; wraps modulo 2^CNTW.

## Operation
- Eligibility: requester i is eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A slot being drained in the same cycle may accept a new operation.
- Arbitration:
  - Round-robin over eligible requesters, starting at pointer ptr.
  - At most one req_ready bit is high per cycle.
  - req_ready is combinational from the current inputs and ptr. It never depends on req_ready itself.
- Pointer update: after a grant to i, ptr becomes (i+1) mod NREQ. With no grant, ptr holds.
- ALU drive:
  - The winner's a, op and cin drive the ALU.
  - For op 5..7, b is replaced by {27'b0, b[4:0]}, which limits shift amounts to 0..31.
  - With no grant, the ALU inputs are driven to zero.
- Cin gating: cin is forced to 0 for op 2..7.
- Flag cleanup: for op 2..7, rsp_flags[2] is forced to 0, so no stale overflow survives. Bits [1] and [0] are taken from the ALU.
- Capture: on a handshake, the ALU output and cleaned flags are written to the slot of the granted requester, and rsp_valid[i] is set.
- Drain: rsp_ready[i] with no new grant to i clears rsp_valid[i]. rsp_result and rsp_flags keep their last values.
- Unsolicited ready: rsp_ready on an empty slot has no effect.
- Stray requests: a request from a requester whose slot is full and not draining is never granted. That requester's req_ready stays 0.
- Request stability: requesters hold req_* stable while valid && !ready. The block does not check this.
- grant_count increments by 1 on each handshake.

## Timing
- Reset values (rst_n low at a rising edge):
  - ptr = 0 and grant_count = 0.
  - All rsp_valid, rsp_result and rsp_flags are 0.
  - req_ready is 0 during the reset cycle.
- Latency: handshake in cycle N gives rsp_valid[i] = 1 and valid data in cycle N+1.
- Throughput: one operation per cycle in aggregate. A single requester that drains every cycle sustains one operation per cycle.
- Simultaneous drain and grant on the same slot: the new result overwrites the slot, and rsp_valid stays 1.
- Reset mid-operation: any in-flight grant is discarded, all slots empty, and ptr returns to 0 on the following cycle.

## Structure
- Package alu_arb_pkg holds:
  - opcode constants OP_ADD..OP_SRA (3'd0..3'd7);
  - flag indices FLAG_OV=2, FLAG_SIGN=1, FLAG_ZERO=0;
  - the shift-mask width SHAMT_W=5.
- Sub-module rr_arbiter (parameter N) provides:
  - eligible vector in, one-hot grant out;
  - the ptr register, with clk and rst_n.
- The top level contains:
  - the ALU instance (existing ALU module);
  - the operand mux, b-masking, cin gating and flag cleanup;
  - the response slots and the counter.

## Test plan
- Reset and idle: hold rst_n=0 for 2 cycles, then release with no requests. Required: rsp_valid=0, rsp_result=0, grant_count=0, req_ready=0 throughout.
- Single ADD: requester 0 issues a=32'h7FFFFFFF, b=1, op=0, cin=0 at cycle N. Required:
  - req_ready[0]=1 in cycle N;
  - in cycle N+1: rsp_result[0]=32'h80000000, rsp_flags[0]=3'b110, grant_count=1.
- Contention: both requesters hold valid continuously and drain every cycle. Required:
  - grants alternate 0,1,0,1,... starting with 0 after reset;
  - requester 0 (ADD 2+3) returns 5, requester 1 (SUB 5-5) returns 0 with flags 3'b001.
- Backpressure: requester 1 holds rsp_ready=0 after one grant while requester 0 keeps requesting. Required:
  - req_ready[1] stays 0 while its slot is full;
  - requester 0 is granted every cycle;
  - asserting rsp_ready[1] with req_valid[1] re-grants 1 in that same cycle.
- Shift masking and flag cleanup: requester 0 issues op=5 with a=1, b=32'h00000021, right after an overflowing ADD. Required:
  - the shift amount is masked to 1, so the ALU shifts a=1 by 1;
  - the result is the ALU output for a=1, b=1;
  - rsp_flags[0][2]=0.
- Reset mid-stream: assert rst_n=0 while slot 0 is full and requester 1 is being granted. Required: on the next cycle all rsp_valid=0 and grant_count=0, and the first grant after release goes to requester 0.
